convergence_monitor: RTL and testbench
======================================

CONVERGENCE_MONITOR -- requirements
Module: convergence_monitor

Interface
REQ-001 Parameter WIDTH, default 16: bit width of the signed error sample.
REQ-002 Parameter WINDOW_LOG2, default 4: each averaging window is 2^WINDOW_LOG2 valid samples.
REQ-003 Parameter HOLD, default 4: consecutive below-threshold windows required to declare convergence (range 1..255).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 sample_valid  input  1  qualifies error in the current cycle.
REQ-007 error  input  WIDTH  signed two's-complement error sample (desired minus filter output).
REQ-008 threshold  input  2*WIDTH  unsigned MSE threshold, sampled at each window end.
REQ-009 clear  input  1  synchronous flush of pipeline, accumulator, counters and state.
REQ-010 mse  output  2*WIDTH  unsigned mean squared error of the last completed window.
REQ-011 mse_valid  output  1  one-cycle pulse when mse is updated.
REQ-012 converged  output  1  high while the state is CONVERGED.
REQ-013 lost  output  1  one-cycle pulse on a CONVERGED -> SEARCH transition.
REQ-014 adapt_en  output  1  equals NOT converged; gates weight updates of the filter.

Function
REQ-015 Stage 1 SHALL register sq = error*error (unsigned, 2*WIDTH bits), a valid flag and a last-of-window flag one cycle after a valid sample.
REQ-016 sample_count (WINDOW_LOG2 bits) SHALL increment on each sample_valid and wrap to 0 after 2^WINDOW_LOG2-1; that sample is flagged last.
REQ-017 Cycles with sample_valid low SHALL not change sample_count or the accumulator.
REQ-018 Accumulator width SHALL be 2*WIDTH+WINDOW_LOG2 bits, so no overflow or saturation is possible.
REQ-019 When stage 1 holds a last sample, mse SHALL load (acc+sq) >> WINDOW_LOG2 (truncation), acc SHALL load 0 and mse_valid SHALL pulse; otherwise acc += sq on stage-1 valid.
REQ-020 Latency: mse_valid SHALL be high exactly 2 cycles after the cycle carrying the last valid sample of a window.
REQ-021 A new window SHALL accumulate in the same cycle the previous one completes (back-to-back windows, no lost samples).
REQ-022 FSM states SEARCH and CONVERGED; below_cnt is an 8-bit counter.
REQ-023 SEARCH, window end, new mse < threshold: below_cnt += 1; if the result equals HOLD -> CONVERGED, below_cnt := 0.
REQ-024 SEARCH, window end, new mse >= threshold: below_cnt := 0 and stay in SEARCH.
REQ-025 CONVERGED, window end, new mse >= threshold -> SEARCH, with lost pulsed in the same cycle as mse_valid; otherwise stay.
REQ-026 converged, lost and mse SHALL update in the same cycle as mse_valid; the comparison uses the newly computed mse and the threshold value in the cycle the window completes.
REQ-027 clear high SHALL zero sample_count, acc, stage-1 flags, below_cnt, mse and all pulses, and force SEARCH; a sample_valid in the same cycle SHALL be dropped.
REQ-028 clear SHALL take priority over a window completion in the same cycle, so no mse_valid or lost is issued.

Reset
REQ-029 While rstn is low: mse=0, mse_valid=0, converged=0, lost=0, adapt_en=1, state SEARCH, and all counters, accumulator and pipeline flags 0.
REQ-030 Deassertion of rstn mid-window SHALL discard the partial window; the first full window starts with the first valid sample after reset.

Verification (WIDTH=16, WINDOW_LOG2=2, HOLD=2)
REQ-031 Reset: rstn low with sample_valid toggling -> all outputs at reset values, adapt_en=1, no mse_valid.
REQ-032 error=100 valid for 4 consecutive cycles -> mse=10000, with mse_valid exactly 2 cycles after the 4th sample.
REQ-033 error=-32768 for 4 samples -> mse=1073741824 with no wrap; then error=0 for 4 samples -> mse=0.
REQ-034 threshold=5000, error=10 for 8 samples -> converged rises on the 2nd mse_valid (mse=100); then error=100 for 4 samples -> converged falls, lost pulses once, adapt_en=1.
REQ-035 error=3 valid on alternate cycles for 4 samples -> a single mse_valid with mse=9; idle cycles are not counted.
REQ-036 2 valid samples, then clear together with a valid sample, then 4 samples of error=2 -> one mse_valid with mse=4, and below_cnt restarts from 0.

Source files
------------

// File: rtl/convergence_monitor.sv
// Windowed mean-squared-error monitor for an adaptive filter.
// It reports convergence once HOLD windows in a row fall below threshold.
module convergence_monitor #(
    parameter int WIDTH       = 16,
    parameter int WINDOW_LOG2 = 4,
    parameter int HOLD        = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      sample_valid,
    input  logic signed [WIDTH-1:0]   error,
    input  logic [2*WIDTH-1:0]        threshold,
    input  logic                      clear,
    output logic [2*WIDTH-1:0]        mse,
    output logic                      mse_valid,
    output logic                      converged,
    output logic                      lost,
    output logic                      adapt_en
);

    localparam int SW = 2 * WIDTH;
    localparam int AW = SW + WINDOW_LOG2;

    typedef enum logic {
        SEARCH,
        CONVERGED
    } state_t;

    state_t                 state_q, state_d;
    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic                   v1_q, v1_d;
    logic                   last1_q, last1_d;
    logic [SW-1:0]          sq1_q, sq1_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [SW-1:0]          mse_q, mse_d;
    logic                   mv_q, mv_d;
    logic                   lost_q, lost_d;
    logic [7:0]             below_q, below_d;

    logic signed [SW-1:0]   err_x;
    logic signed [SW-1:0]   sq_s;
    logic [AW-1:0]          acc_sum;
    logic [SW-1:0]          mse_new;
    logic [7:0]             below_inc;

    // Sign-extend first so the truncated product is the exact square.
    assign err_x   = SW'(error);
    assign sq_s    = err_x * err_x;
    assign acc_sum = acc_q + AW'(sq1_q);
    assign mse_new = SW'(acc_sum >> WINDOW_LOG2);
    assign below_inc = below_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v1_d    = 1'b0;
        last1_d = 1'b0;
        sq1_d   = sq1_q;
        acc_d   = acc_q;
        mse_d   = mse_q;
        mv_d    = 1'b0;
        lost_d  = 1'b0;
        below_d = below_q;
        if (clear) begin
            state_d = SEARCH;
            cnt_d   = '0;
            sq1_d   = '0;
            acc_d   = '0;
            mse_d   = '0;
            below_d = '0;
        end else begin
            if (sample_valid) begin
                sq1_d   = unsigned'(sq_s);
                v1_d    = 1'b1;
                last1_d = &cnt_q;
                cnt_d   = cnt_q + 1'b1;
            end
            if (v1_q && last1_q) begin
                acc_d = '0;
                mse_d = mse_new;
                mv_d  = 1'b1;
                unique case (state_q)
                    SEARCH: begin
                        if (mse_new < threshold) begin
                            if (below_inc == 8'(HOLD)) begin
                                state_d = CONVERGED;
                                below_d = '0;
                            end else begin
                                below_d = below_inc;
                            end
                        end else begin
                            below_d = '0;
                        end
                    end
                    CONVERGED: begin
                        if (mse_new >= threshold) begin
                            state_d = SEARCH;
                            lost_d  = 1'b1;
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end else if (v1_q) begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SEARCH;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            sq1_q   <= '0;
            acc_q   <= '0;
            mse_q   <= '0;
            mv_q    <= 1'b0;
            lost_q  <= 1'b0;
            below_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v1_q    <= v1_d;
            last1_q <= last1_d;
            sq1_q   <= sq1_d;
            acc_q   <= acc_d;
            mse_q   <= mse_d;
            mv_q    <= mv_d;
            lost_q  <= lost_d;
            below_q <= below_d;
        end
    end

    assign mse       = mse_q;
    assign mse_valid = mv_q;
    assign converged = (state_q == CONVERGED);
    assign lost      = lost_q;
    assign adapt_en  = (state_q != CONVERGED);

endmodule

// File: tb/tb_convergence_monitor.sv
// Directed and random checks of convergence_monitor against a
// window-level reference model (WIDTH=16, WINDOW_LOG2=2, HOLD=2).
module tb_convergence_monitor;

    localparam int W    = 16;
    localparam int L2   = 2;
    localparam int HOLD = 2;
    localparam int WIN  = 1 << L2;

    logic            clk;
    logic            rstn;
    logic            sample_valid;
    logic [W-1:0]    error;
    logic [2*W-1:0]  threshold;
    logic            clear;
    logic [2*W-1:0]  mse;
    logic            mse_valid;
    logic            converged;
    logic            lost;
    logic            adapt_en;

    convergence_monitor #(
        .WIDTH(W),
        .WINDOW_LOG2(L2),
        .HOLD(HOLD)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .sample_valid(sample_valid),
        .error(error),
        .threshold(threshold),
        .clear(clear),
        .mse(mse),
        .mse_valid(mse_valid),
        .converged(converged),
        .lost(lost),
        .adapt_en(adapt_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: list of squares in the open window, one pending
    // completed window, and the search/converged decision.
    longint win_sq[$];
    bit     pend_v;
    longint pend_sum;
    bit     m_conv;
    int     m_below;
    longint e_mse;
    bit     e_mv;
    bit     e_lost;

    task automatic mreset();
        win_sq.delete();
        pend_v  = 0;
        pend_sum = 0;
        m_conv  = 0;
        m_below = 0;
        e_mse   = 0;
        e_mv    = 0;
        e_lost  = 0;
    endtask

    task automatic model_edge(input bit v, input int e, input bit c,
                              input longint thr);
        longint m;
        longint s;
        e_mv   = 0;
        e_lost = 0;
        if (c) begin
            mreset();
            return;
        end
        if (pend_v) begin
            m = pend_sum / WIN;
            e_mse = m;
            e_mv  = 1;
            if (!m_conv) begin
                if (m < thr) begin
                    m_below++;
                    if (m_below == HOLD) begin
                        m_conv  = 1;
                        m_below = 0;
                    end
                end else begin
                    m_below = 0;
                end
            end else if (m >= thr) begin
                m_conv = 0;
                e_lost = 1;
            end
        end
        pend_v = 0;
        if (v) begin
            win_sq.push_back(longint'(e) * longint'(e));
            if (win_sq.size() == WIN) begin
                s = 0;
                foreach (win_sq[i]) s += win_sq[i];
                pend_sum = s;
                pend_v   = 1;
                win_sq.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("mse_valid", 64'(mse_valid), 64'(e_mv));
        chk("mse", 64'(mse), 64'(e_mse));
        chk("converged", 64'(converged), 64'(m_conv));
        chk("lost", 64'(lost), 64'(e_lost));
        chk("adapt_en", 64'(adapt_en), 64'(!m_conv));
    endtask

    task automatic cyc(input bit v, input int e, input bit c);
        sample_valid = v;
        error        = W'(e);
        clear        = c;
        @(posedge clk);
        if (!rstn) mreset();
        else model_edge(v, e, c, longint'(threshold));
        #1;
        check_all();
    endtask

    task automatic burst(input int n, input int e);
        for (int i = 0; i < n; i++) cyc(1'b1, e, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
    endtask

    int lost_cnt;
    int e_r;

    initial begin
        rstn         = 1'b0;
        sample_valid = 1'b0;
        error        = '0;
        clear        = 1'b0;
        threshold    = 32'd5000;
        mreset();

        // Reset held with samples toggling
        for (int i = 0; i < 4; i++) cyc(i[0], 77, 1'b0);
        chk("rst_adapt_en", 64'(adapt_en), 64'd1);
        rstn = 1'b1;

        // Constant error 100: mse 10000, two cycles after last sample
        burst(4, 100);
        chk("lat_not_early", 64'(mse_valid), 64'd0);
        idle(1);
        chk("req032_mv", 64'(mse_valid), 64'd1);
        chk("req032_mse", 64'(mse), 64'd10000);
        idle(2);

        // Most negative sample squares without wrap
        burst(4, -32768);
        idle(2);
        chk("req033_big", 64'(mse), 64'd1073741824);
        burst(4, 0);
        idle(2);
        chk("req033_zero", 64'(mse), 64'd0);

        // Convergence on 2nd quiet window, then loss
        cyc(1'b0, 0, 1'b1);
        burst(4, 10);
        idle(2);
        chk("req034_w1", 64'(converged), 64'd0);
        burst(4, 10);
        idle(2);
        chk("req034_mse", 64'(mse), 64'd100);
        chk("req034_conv", 64'(converged), 64'd1);
        lost_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 100, 1'b0);
            lost_cnt += int'(lost);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 0, 1'b0);
            lost_cnt += int'(lost);
        end
        chk("req034_lost_once", 64'(lost_cnt), 64'd1);
        chk("req034_adapt", 64'(adapt_en), 64'd1);

        // Alternate-cycle samples
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 3, 1'b0);
            cyc(1'b0, 0, 1'b0);
        end
        idle(1);
        chk("req035_mse", 64'(mse), 64'd9);

        // Clear mid-window drops the sample in the clear cycle
        burst(2, 7);
        cyc(1'b1, 7, 1'b1);
        burst(4, 2);
        idle(2);
        chk("req036_mse", 64'(mse), 64'd4);
        chk("req036_not_conv", 64'(converged), 64'd0);
        burst(4, 2);
        idle(2);
        chk("req036_conv", 64'(converged), 64'd1);

        // Clear in the completion cycle suppresses mse_valid
        burst(4, 200);
        cyc(1'b0, 0, 1'b1);
        chk("clr_prio_mv", 64'(mse_valid), 64'd0);
        idle(3);

        // Reset mid-window discards the partial window
        burst(2, 50);
        rstn = 1'b0;
        cyc(1'b1, 50, 1'b0);
        rstn = 1'b1;
        burst(4, 5);
        idle(2);
        chk("rst_mid_mse", 64'(mse), 64'd25);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0)
                threshold = 32'($urandom_range(50, 600));
            e_r = int'($urandom_range(0, 60)) - 30;
            if ($urandom_range(0, 9) == 0)
                e_r = int'($urandom_range(0, 65535)) - 32768;
            cyc($urandom_range(0, 3) != 0, e_r,
                $urandom_range(0, 59) == 0);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
